// File: rtl/vote_button_arbiter.sv
// Multi-channel vote qualifier: accepts a vote when exactly one synchronised
// button is held for HOLD_CYCLES clocks while enabled; flags multi-press attempts.
module vote_button_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int HOLD_CYCLES = 100000000,
  parameter int CNT_W       = 31,
  parameter int TOTAL_W     = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_CH-1:0]  button,
  output logic               vote_valid,
  output logic [CH_W-1:0]    vote_ch,
  output logic               multi_press,
  output logic               busy,
  output logic [TOTAL_W-1:0] vote_total
);

  typedef enum logic [1:0] {IDLE, QUALIFY, FIRE, LOCKOUT} state_t;

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   sync1_q, s_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [CH_W-1:0]     vote_ch_q, vote_ch_d;
  logic [TOTAL_W-1:0]  total_q, total_d;
  logic                vote_valid_q, vote_valid_d;
  logic                multi_q, multi_d;
  logic                busy_q, busy_d;

  logic [CH_W:0]       pop_cnt;
  logic [CH_W-1:0]     idx;
  logic [NUM_CH-1:0]   ch_mask;
  logic                one, many, none;

  always_comb begin
    pop_cnt = '0;
    idx     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pop_cnt = pop_cnt + (CH_W+1)'(s_q[i]);
      if (s_q[i]) idx = CH_W'(i);
    end
  end

  assign one     = (pop_cnt == (CH_W+1)'(1));
  assign many    = (pop_cnt >= (CH_W+1)'(2));
  assign none    = (s_q == '0);
  assign ch_mask = NUM_CH'(1) << ch_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ch_d         = ch_q;
    vote_ch_d    = vote_ch_q;
    total_d      = total_q;
    vote_valid_d = 1'b0;
    multi_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && one) begin
          state_d = QUALIFY;
          cnt_d   = '0;
          ch_d    = idx;
        end else if (enable && many) begin
          state_d = LOCKOUT;
          multi_d = 1'b1;
        end
      end
      QUALIFY: begin
        // A second button wins over hold completion in the same cycle.
        if (many) begin
          state_d = LOCKOUT;
          multi_d = 1'b1;
        end else if (!enable) begin
          state_d = LOCKOUT;
        end else if (none) begin
          state_d = IDLE;
        end else if (s_q != ch_mask) begin
          state_d = LOCKOUT;
          multi_d = 1'b1;
        end else if (cnt_q == CNT_W'(HOLD_CYCLES-1)) begin
          // Strobe, channel and total are registered on entry so they are visible during FIRE.
          state_d      = FIRE;
          vote_valid_d = 1'b1;
          vote_ch_d    = ch_q;
          total_d      = (&total_q) ? total_q : total_q + TOTAL_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FIRE:    state_d = LOCKOUT;
      LOCKOUT: if (none) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q      <= '0;
      s_q          <= '0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      ch_q         <= '0;
      vote_ch_q    <= '0;
      total_q      <= '0;
      vote_valid_q <= 1'b0;
      multi_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync1_q      <= button;
      s_q          <= sync1_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ch_q         <= ch_d;
      vote_ch_q    <= vote_ch_d;
      total_q      <= total_d;
      vote_valid_q <= vote_valid_d;
      multi_q      <= multi_d;
      busy_q       <= busy_d;
    end
  end

  assign vote_valid  = vote_valid_q;
  assign vote_ch     = vote_ch_q;
  assign multi_press = multi_q;
  assign busy        = busy_q;
  assign vote_total  = total_q;

endmodule
